// File: rtl/cim_mac_sequencer.sv
// rtl/cim_mac_sequencer.sv - dot-product job sequencer for one cim_core (optional CIM_RELU_EN clamps negative results to 0)
module cim_mac_sequencer #(
    parameter int XIN_BIT_WIDTH       = 11,
    parameter int MEM_BIT_WIDTH       = 8,
    parameter int CORE_DOUT_BIT_WIDTH = XIN_BIT_WIDTH + MEM_BIT_WIDTH - 1,
    parameter int MEM_ADR_WIDTH       = 2,
    parameter int MEM_DEPTH           = 1 << MEM_ADR_WIDTH,
    parameter int ACC_WIDTH           = CORE_DOUT_BIT_WIDTH + MEM_ADR_WIDTH + 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           w_valid,
    output logic                           w_ready,
    input  logic [MEM_ADR_WIDTH-1:0]       w_adr,
    input  logic [MEM_BIT_WIDTH-1:0]       w_data,
    input  logic                           job_valid,
    output logic                           job_ready,
    input  logic [MEM_ADR_WIDTH-1:0]       job_base,
    input  logic [MEM_ADR_WIDTH:0]         job_len,
    input  logic                           x_valid,
    output logic                           x_ready,
    input  logic [XIN_BIT_WIDTH-1:0]       x_data,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [ACC_WIDTH-1:0]           res_data,
    output logic [MEM_ADR_WIDTH-1:0]       core_wadr,
    output logic [MEM_ADR_WIDTH-1:0]       core_radr,
    output logic                           core_web,
    output logic                           core_reb,
    output logic                           core_encb,
    output logic [MEM_BIT_WIDTH-1:0]       core_din,
    output logic [XIN_BIT_WIDTH-1:0]       core_xin,
    input  logic [CORE_DOUT_BIT_WIDTH-1:0] core_dout
);

    localparam int LEN_W = MEM_ADR_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                   state;
    logic [MEM_ADR_WIDTH-1:0] base;
    logic [LEN_W-1:0]         len;
    logic [LEN_W-1:0]         issued;
    logic [LEN_W-1:0]         eff_len;
    logic [1:0]               vpipe;
    logic [ACC_WIDTH-1:0]     acc;
    logic [ACC_WIDTH-1:0]     acc_next;
    logic [ACC_WIDTH-1:0]     mag;
    logic [ACC_WIDTH-1:0]     term;
    logic [ACC_WIDTH-1:0]     res_pre;
    logic                     x_hs;
    logic                     job_hs;
    logic                     w_hs;

    // Handshakes and host-facing ready flags; a pending write blocks a job in the same cycle
    always_comb begin
        w_ready   = (state == IDLE);
        job_ready = (state == IDLE) && !w_valid;
        x_ready   = (state == RUN) && (issued < len);
        w_hs      = w_valid && w_ready;
        job_hs    = job_valid && job_ready;
        x_hs      = x_valid && x_ready;
        eff_len   = (job_len > LEN_W'(MEM_DEPTH)) ? LEN_W'(MEM_DEPTH) : job_len;
    end

    // Core control pins: write and read enables follow the handshakes in the same cycle
    always_comb begin
        core_web  = !w_hs;
        core_wadr = w_adr;
        core_din  = w_data;
        core_reb  = 1'b1;
        core_encb = !x_hs;
        core_radr = base + issued[MEM_ADR_WIDTH-1:0];
    end

    // Sign-magnitude product to two's complement; negative zero naturally adds nothing
    always_comb begin
        mag      = {{(ACC_WIDTH - CORE_DOUT_BIT_WIDTH + 1){1'b0}}, core_dout[CORE_DOUT_BIT_WIDTH-2:0]};
        term     = core_dout[CORE_DOUT_BIT_WIDTH-1] ? (~mag + 1'b1) : mag;
        acc_next = vpipe[1] ? (acc + term) : acc;
`ifdef CIM_RELU_EN
        res_pre  = acc_next[ACC_WIDTH-1] ? '0 : acc_next;
`else
        res_pre  = acc_next;
`endif
    end

    // Job FSM, product-alignment valid pipe, accumulator and registered result
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            base      <= '0;
            len       <= '0;
            issued    <= '0;
            vpipe     <= '0;
            acc       <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            core_xin  <= '0;
        end else begin
            vpipe <= {vpipe[0], x_hs};
            acc   <= acc_next;
            if (x_hs) begin
                core_xin <= x_data;
            end
            case (state)
                IDLE: begin
                    if (job_hs) begin
                        base   <= job_base;
                        issued <= '0;
                        acc    <= '0;
                        len    <= eff_len;
                        if (job_len == '0) begin
                            res_data  <= '0;
                            res_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (x_hs) begin
                        issued <= issued + 1'b1;
                        if (issued + 1'b1 == len) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Last product is on core_dout once only stage 2 of the pipe is occupied
                    if (vpipe == 2'b10) begin
                        res_data  <= res_pre;
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
